// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// ----------------
// Issue-side scoreboard plus a two-requester writeback arbiter that feeds a
// single registered register-file write port.
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   iss_valid/iss_ready        issue handshake; fire = iss_valid & iss_ready
//   iss_rs1/iss_rs2/iss_rd     source and destination register indices
//   iss_wen                    issued instruction writes iss_rd
//   alu_valid/alu_ready        ALU writeback request (alu_rd, alu_data)
//   lsu_valid/lsu_ready        load writeback request (lsu_rd, lsu_data)
//   rf_we/rf_waddr/rf_wdata    registered regfile write port (1-cycle latency)
//   busy                       pending-write scoreboard, bit 0 always clear
//   wb_err                     sticky flag: writeback granted to a non-busy reg
module regfile_wb_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rs1,
    input  logic [4:0]  iss_rs2,
    input  logic [4:0]  iss_rd,
    input  logic        iss_wen,
    output logic        iss_ready,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [63:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [63:0] lsu_data,
    output logic        lsu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic [31:0] busy,
    output logic        wb_err
);

    logic [31:0] busy_reg, busy_next;
    logic        rf_we_reg, rf_we_next;
    logic [4:0]  rf_waddr_reg, rf_waddr_next;
    logic [63:0] rf_wdata_reg, rf_wdata_next;
    logic        wb_err_reg, wb_err_next;
    // 1 = LSU won the most recent cycle in which both requesters were valid.
    logic        last_lsu_reg, last_lsu_next;

    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [31:0] pending;
    logic        iss_fire;

    logic        alu_gnt, lsu_gnt, gnt_any, both_valid;
    logic [4:0]  gnt_rd;
    logic [63:0] gnt_data;

    // A reset cycle must never produce a regfile write, even if a write was
    // registered on the previous edge.
    assign rf_we = rf_we_reg & ~rst;

    // Per-register scoreboard. A register being written this cycle is not
    // pending because the regfile forwards rf_wdata to same-cycle reads. On
    // a simultaneous set and clear of the same index the set wins.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_sb
            assign set_vec[gi] = iss_fire & iss_wen & (iss_rd == 5'(gi));
            assign clr_vec[gi] = rf_we & (rf_waddr_reg == 5'(gi));
            assign pending[gi] = busy_reg[gi] & ~clr_vec[gi];
            if (gi == 0) begin : g_x0
                assign busy_next[gi] = 1'b0;
            end else begin : g_xn
                assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
            end
        end
    endgenerate

    assign iss_ready = ~rst & ~(pending[iss_rs1] | pending[iss_rs2] |
                                (iss_wen & pending[iss_rd]));
    assign iss_fire  = iss_valid & iss_ready;

    // Writeback arbitration: a sole requester always wins; on contention the
    // requester that lost the previous contended cycle wins.
    always_comb begin
        both_valid    = alu_valid & lsu_valid;
        alu_gnt       = ~rst & alu_valid & (~lsu_valid | last_lsu_reg);
        lsu_gnt       = ~rst & lsu_valid & (~alu_valid | ~last_lsu_reg);
        gnt_any       = alu_gnt | lsu_gnt;
        gnt_rd        = lsu_gnt ? lsu_rd   : alu_rd;
        gnt_data      = lsu_gnt ? lsu_data : alu_data;

        last_lsu_next = both_valid ? lsu_gnt : last_lsu_reg;

        // x0 writebacks complete the handshake but never reach the regfile.
        rf_we_next    = gnt_any & (gnt_rd != 5'd0);
        rf_waddr_next = rf_we_next ? gnt_rd   : rf_waddr_reg;
        rf_wdata_next = rf_we_next ? gnt_data : rf_wdata_reg;
        wb_err_next   = wb_err_reg | (rf_we_next & ~busy_reg[gnt_rd]);
    end

    assign alu_ready = alu_gnt;
    assign lsu_ready = lsu_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg     <= '0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
            wb_err_reg   <= 1'b0;
            last_lsu_reg <= 1'b0;
        end else begin
            busy_reg     <= busy_next;
            rf_we_reg    <= rf_we_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_wdata_reg <= rf_wdata_next;
            wb_err_reg   <= wb_err_next;
            last_lsu_reg <= last_lsu_next;
        end
    end

    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;
    assign busy     = busy_reg;
    assign wb_err   = wb_err_reg;

endmodule
